tx_cell_queue: RTL and testbench

Per-port ATM cell elastic buffer between the forwarding/rewrite core and one ATM-layer Utopia transmitter. Accepts rewritten NNI cells through the core's four-phase valid/ready handshake, stores up to `Depth` cells in a circular buffer, and replays them to the transmitter with the same handshake. This decouples the core's arbitration loop from a slow or stalled Tx link. One instance per Tx port.

---
 rtl/tx_cell_queue.sv | 179 +++++++++++++++++
 tb/tb_tx_cell_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_cell_queue.sv
// Per-port ATM cell elastic buffer between the rewrite core and one Utopia Tx port.
// Optional feature: define TXQ_HEC_CHECK_EN to drop (and count) captured cells with a bad HEC.
package tx_cell_queue_pkg;

    typedef struct packed {
        logic [11:0]       VPI;
        logic [15:0]       VCI;
        logic [2:0]        PT;
        logic              CLP;
        logic [7:0]        HEC;
        logic [0:47][7:0]  Payload;
    } NNICellType;

    typedef union packed {
        logic [0:52][7:0]  Mem;
        NNICellType        nni;
    } ATMCellType;

endpackage

module tx_cell_queue
    import tx_cell_queue_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  ATMCellType      in_cell,
    output logic            out_valid,
    input  logic            out_ready,
    output ATMCellType      out_cell,
    output logic [CntW-1:0] count,
    output logic            full,
    output logic            empty,
    output logic [15:0]     drop_cnt
);

    localparam int unsigned PtrW = $clog2(Depth);

    typedef enum logic { IN_IDLE, IN_ACK }    in_state_e;
    typedef enum logic { OUT_IDLE, OUT_WAIT } out_state_e;

    in_state_e        in_state_q, in_state_d;
    out_state_e       out_state_q, out_state_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             out_valid_q, out_valid_d;
    ATMCellType       out_cell_q, out_cell_d;
    logic [15:0]      drop_q, drop_d;
    logic             push, pop, drop;
    ATMCellType       mem [Depth];

`ifdef TXQ_HEC_CHECK_EN
    // CRC-8 (x^8 + x^2 + x + 1) over the four header bytes, MSB first, with the 0x55 coset.
    function automatic logic [7:0] hec(input logic [0:3][7:0] hdr);
        logic [7:0] crc;
        logic       fb;
        crc = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                fb  = crc[7] ^ hdr[i][3'(7 - b)];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc ^ 8'h55;
    endfunction
`endif

    always_comb begin
        in_state_d = in_state_q;
        wr_ptr_d   = wr_ptr_q;
        in_ready   = 1'b0;
        push       = 1'b0;
        drop       = 1'b0;
        unique case (in_state_q)
            IN_IDLE: begin
                in_ready = !full_q;
                if (in_valid && !full_q) begin
                    in_state_d = IN_ACK;
`ifdef TXQ_HEC_CHECK_EN
                    if (hec(in_cell.Mem[0:3]) != in_cell.nni.HEC) drop = 1'b1;
                    else                                         push = 1'b1;
`else
                    push = 1'b1;
`endif
                end
            end
            IN_ACK: begin
                if (!in_valid) in_state_d = IN_IDLE;
            end
            default: in_state_d = IN_IDLE;
        endcase
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    end

    always_comb begin
        out_state_d = out_state_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_cell_d  = out_cell_q;
        pop         = 1'b0;
        unique case (out_state_q)
            OUT_IDLE: begin
                if (!empty_q && out_ready) begin
                    out_cell_d  = mem[rd_ptr_q];
                    out_valid_d = 1'b1;
                    out_state_d = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                // The head entry is only retired once the transmitter acknowledges.
                if (!out_ready) begin
                    out_valid_d = 1'b0;
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    pop         = 1'b1;
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CntW'(Depth));
        empty_d = (count_d == '0);
        drop_d  = drop_q;
        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_cell_q  <= '0;
            drop_q      <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            out_valid_q <= out_valid_d;
            out_cell_q  <= out_cell_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_cell;
    end

    assign out_valid = out_valid_q;
    assign out_cell  = out_cell_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tx_cell_queue.sv
// Directed bench for tx_cell_queue: cycle table plus handshake sequences for corner cases.
module tb_tx_cell_queue;
    import tx_cell_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    ATMCellType  in_cell = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    ATMCellType  out_cell;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] drop_cnt;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    always #5 clk = ~clk;

    tx_cell_queue #(.Depth(4)) dut (
        .clk(clk), .reset(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
        .out_valid(out_valid), .out_ready(out_ready), .out_cell(out_cell),
        .count(count), .full(full), .empty(empty), .drop_cnt(drop_cnt)
    );

    function automatic void check(input string name, input logic [423:0] act, input logic [423:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] tb_hec(input logic [31:0] h);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = r[7] ^ h[i];
            r  = r << 1;
            if (fb) r = r ^ 8'h07;
        end
        return r ^ 8'h55;
    endfunction

    function automatic ATMCellType make_cell(input logic [11:0] vpi, input logic good);
        ATMCellType c;
        c = '0;
        c.nni.VPI = vpi;
        c.nni.VCI = {4'h0, vpi} ^ 16'h1234;
        c.nni.PT  = vpi[2:0];
        c.nni.CLP = vpi[0];
        for (int i = 0; i < 48; i++) c.nni.Payload[i] = vpi[7:0] + 8'(i);
        c.nni.HEC = tb_hec({c.Mem[0], c.Mem[1], c.Mem[2], c.Mem[3]}) ^ (good ? 8'h00 : 8'hFF);
        return c;
    endfunction

    task automatic push_cell(input ATMCellType c);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", in_ready, 1'b1);
        in_cell  = c;
        in_valid = 1'b1;
        @(negedge clk);
        check("push_ack", in_ready, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_expect(input ATMCellType c);
        int unsigned n;
        n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pop_valid", out_valid, 1'b1);
        check("pop_cell", out_cell, c);
        out_ready = 1'b0;
        @(negedge clk);
        check("pop_release", out_valid, 1'b0);
    endtask

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [11:0] vin;
        logic        ir;
        logic        ov;
        logic [11:0] vout;   // 12'hFFF stands for the all-zero reset cell
        int unsigned cnt;
        logic        fl;
        logic        em;
    } vec_t;

    vec_t tbl [23];

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ATMCellType exp_cell;
        int unsigned ov_hi, ir_lo;

        tbl[0]  = '{1'b1, 1'b1, 12'h0A5, 1'b0, 1'b0, 12'hFFF, 1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 12'h0A5, 1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 12'h0A5, 0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 12'h0A5, 1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 12'h002, 1'b0, 1'b0, 12'h0A5, 2, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 2, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 12'h003, 1'b0, 1'b0, 12'h0A5, 3, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h0A5, 3, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 12'h004, 1'b0, 1'b0, 12'h0A5, 4, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 12'h0A5, 4, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 12'h0A5, 4, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h0A5, 4, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 12'h001, 4, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h001, 3, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 12'h002, 3, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h002, 2, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 12'h003, 2, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h003, 1, 1'b0, 1'b0};
        tbl[21] = '{1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 12'h004, 1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 12'h004, 0, 1'b0, 1'b1};

        // Reset state
        #23;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_cell", out_cell, '0);
        check("rst_count", count, 3'd0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
        check("rst_drop", drop_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table: cut-through, fill to full, stalled 5th push, in-order drain
        for (int unsigned k = 0; k < 23; k++) begin
            @(negedge clk);
            in_valid  = tbl[k].iv;
            out_ready = tbl[k].ordy;
            in_cell   = make_cell(tbl[k].vin, 1'b1);
            @(posedge clk);
            #1;
            exp_cell = (tbl[k].vout == 12'hFFF) ? ATMCellType'('0) : make_cell(tbl[k].vout, 1'b1);
            check($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].ir);
            check($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].ov);
            check($sformatf("tbl%0d_out_cell", k), out_cell, exp_cell);
            check($sformatf("tbl%0d_count", k), count, 3'(tbl[k].cnt));
            check($sformatf("tbl%0d_full", k), full, tbl[k].fl);
            check($sformatf("tbl%0d_empty", k), empty, tbl[k].em);
        end
        @(negedge clk);
        in_valid = 1'b0;

        // Pointer wrap: two batches of three
        for (int unsigned b = 0; b < 2; b++) begin
            for (int unsigned i = 0; i < 3; i++) push_cell(make_cell(12'h010 + 12'(3 * b + i), 1'b1));
            check("wrap_count", count, 3'd3);
            for (int unsigned i = 0; i < 3; i++) pop_expect(make_cell(12'h010 + 12'(3 * b + i), 1'b1));
        end
        check("wrap_empty", empty, 1'b1);

        // Simultaneous push and pop with count == 2
        push_cell(make_cell(12'h050, 1'b1));
        push_cell(make_cell(12'h051, 1'b1));
        out_ready = 1'b1;
        @(negedge clk);
        check("simul_head_valid", out_valid, 1'b1);
        check("simul_head_cell", out_cell, make_cell(12'h050, 1'b1));
        check("simul_pre_ready", in_ready, 1'b1);
        in_cell   = make_cell(12'h052, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("simul_count", count, 3'd2);
        check("simul_in_ack", in_ready, 1'b0);
        check("simul_out_drop", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        pop_expect(make_cell(12'h051, 1'b1));
        pop_expect(make_cell(12'h052, 1'b1));
        check("simul_final_count", count, 3'd0);

        // Stalled transmitter with one cell queued
        push_cell(make_cell(12'h030, 1'b1));
        ov_hi = 0;
        ir_lo = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) ov_hi++;
            if (!in_ready) ir_lo++;
        end
        check("stall_out_valid_cycles", ov_hi, 0);
        check("stall_in_ready_low_cycles", ir_lo, 0);
        for (int unsigned i = 1; i < 4; i++) push_cell(make_cell(12'h030 + 12'(i), 1'b1));
        check("stall_full", full, 1'b1);
        check("stall_in_ready_full", in_ready, 1'b0);
        for (int unsigned i = 0; i < 4; i++) pop_expect(make_cell(12'h030 + 12'(i), 1'b1));
        check("stall_drained", empty, 1'b1);

        // Corrupted HEC
        push_cell(make_cell(12'h040, 1'b0));
        check("hec_in_ready_back", in_ready, 1'b1);
`ifdef TXQ_HEC_CHECK_EN
        check("hec_count", count, 3'd0);
        check("hec_drop", drop_cnt, 16'd1);
`else
        check("hec_count", count, 3'd1);
        check("hec_drop", drop_cnt, 16'd0);
        pop_expect(make_cell(12'h040, 1'b0));
`endif

        // Reset mid-transfer
        push_cell(make_cell(12'h060, 1'b1));
        push_cell(make_cell(12'h061, 1'b1));
        out_ready = 1'b1;
        @(negedge clk);
        check("mrst_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_count", count, 3'd0);
        check("mrst_empty", empty, 1'b1);
        check("mrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        out_ready = 1'b0;
        rst_n     = 1'b1;
        push_cell(make_cell(12'h077, 1'b1));
        check("mrst_new_count", count, 3'd1);
        pop_expect(make_cell(12'h077, 1'b1));
        check("mrst_new_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
